// File: rtl/unfifo_pkg.sv
// Shared constants for the single-entry toggle-handshake mailbox.
package unfifo_pkg;

  localparam int DSIZE_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Legal depth range for each handshake flop chain
  localparam int SYNC_STAGES_MIN = 1;
  localparam int SYNC_STAGES_MAX = 4;

  // True when a chain depth is within the supported range
  function automatic bit sync_depth_ok(input int depth);
    return (depth >= SYNC_STAGES_MIN) && (depth <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/unfifo_sync.sv
// Parameterised 1-bit flop chain carrying one handshake toggle across a
// fixed number of cycles; every stage resets to 0.
module unfifo_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the toggle one stage per cycle; clear the whole chain on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/unfifo_mailbox.sv
// Single-entry mailbox with a FIFO-style interface. A write flips wtog,
// a pop flips rtog; each toggle reaches the other side through a fixed
// flop chain, so full/empty timing is deterministic.
module unfifo_mailbox
  import unfifo_pkg::*;
#(
  parameter int DSIZE       = DSIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             winc_i,
  input  logic [DSIZE-1:0] wdata_i,
  output logic             wfull_o,
  input  logic             rinc_i,
  output logic             rempty_o,
  output logic [DSIZE-1:0] rdata_o
);

  if (!sync_depth_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("unfifo_mailbox: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic [DSIZE-1:0] mem;
  logic             wtog;
  logic             rtog;
  logic             req_q;
  logic             ack_q;
  logic             wr_acc;
  logic             rd_acc;

  // Request path: writer toggle delayed towards the reader
  unfifo_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (wtog),
    .q     (req_q)
  );

  // Ack path: reader toggle delayed back towards the writer
  unfifo_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rtog),
    .q     (ack_q)
  );

  // Flags come straight from registers, so no input reaches an output
  assign wfull_o  = (wtog != ack_q);
  assign rempty_o = (req_q == rtog);
  assign rdata_o  = mem;

  // Requests against an asserted flag are silently dropped
  assign wr_acc = winc_i & ~wfull_o;
  assign rd_acc = rinc_i & ~rempty_o;

  // Writer side: capture the word and announce it by flipping wtog
  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      wtog <= 1'b0;
    end else if (wr_acc) begin
      mem  <= wdata_i;
      wtog <= ~wtog;
    end
  end

  // Reader side: a pop only flips rtog; the word itself stays in mem
  always_ff @(posedge clk) begin
    if (reset) begin
      rtog <= 1'b0;
    end else if (rd_acc) begin
      rtog <= ~rtog;
    end
  end

endmodule

// File: tb/tb_unfifo_mailbox.sv
// Bench for unfifo_mailbox: directed scenarios plus random traffic,
// all compared against an occupancy/latency model of the mailbox.
module tb_unfifo_mailbox;

  localparam int DW = 16;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          winc_i;
  logic [DW-1:0] wdata_i;
  logic          wfull_o;
  logic          rinc_i;
  logic          rempty_o;
  logic [DW-1:0] rdata_o;

  unfifo_mailbox #(.DSIZE(DW), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .winc_i   (winc_i),
    .wdata_i  (wdata_i),
    .wfull_o  (wfull_o),
    .rinc_i   (rinc_i),
    .rempty_o (rempty_o),
    .rdata_o  (rdata_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a word is either held or not; visibility and
  // release each lag by S edges.
  int          cyc      = 0;
  int          avail_at = 0;
  int          free_at  = 0;
  bit          has_word = 1'b0;
  logic [DW-1:0] word   = '0;
  bit          m_wfull  = 1'b0;
  bit          m_rempty = 1'b1;

  // DUT-observed acceptance on the most recent edge
  bit            dut_wacc;
  bit            dut_pop;
  logic [DW-1:0] pop_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
    logic pre_wfull, pre_rempty;
    winc_i  = w;
    wdata_i = d;
    rinc_i  = r;
    reset   = rs;
    pre_wfull  = wfull_o;
    pre_rempty = rempty_o;
    pop_data   = rdata_o;
    @(posedge clk);
    dut_wacc = !rs && w && !pre_wfull;
    dut_pop  = !rs && r && !pre_rempty;
    if (rs) begin
      cyc = 0; avail_at = 0; free_at = 0; has_word = 1'b0; word = '0;
    end else begin
      cyc++;
      if (w && !m_wfull) begin
        has_word = 1'b1; word = d; avail_at = cyc + S;
      end
      if (r && !m_rempty) begin
        has_word = 1'b0; free_at = cyc + S;
      end
    end
    m_wfull  = has_word || (cyc < free_at);
    m_rempty = !has_word || (cyc < avail_at);
    #1;
    chk("wfull",  {15'b0, wfull_o},  {15'b0, m_wfull});
    chk("rempty", {15'b0, rempty_o}, {15'b0, m_rempty});
    chk("rdata",  rdata_o, word);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int pops;
    int rx_exp;
    int nxt;
    int last_w;
    bit seen_beef;

    winc_i = 0; wdata_i = '0; rinc_i = 0; reset = 1;
    @(negedge clk);

    // Reset with random requests, then release
    step($urandom_range(1), 16'($urandom), $urandom_range(1), 1'b1);
    step($urandom_range(1), 16'($urandom), $urandom_range(1), 1'b1);
    chk("reset_rempty", {15'b0, rempty_o}, 16'h1);
    chk("reset_wfull",  {15'b0, wfull_o},  16'h0);
    chk("reset_rdata",  rdata_o, 16'h0000);

    // Empty pops are ignored, a later write is delivered exactly once
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'h3C3C, 1'b0, 1'b0);
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (dut_pop) begin
        pops++;
        chk("emptypop_data", pop_data, 16'h3C3C);
      end
    end
    chk("emptypop_count", 16'(pops), 16'd1);

    // Single transfer with explicit edge timing
    idle(3);
    step(1'b1, 16'hA5C3, 1'b0, 1'b0);               // edge k
    chk("single_full_k", {15'b0, wfull_o}, 16'h1);
    step(1'b0, '0, 1'b0, 1'b0);                     // k+1
    chk("single_empty_k1", {15'b0, rempty_o}, 16'h1);
    step(1'b0, '0, 1'b0, 1'b0);                     // k+2
    chk("single_avail_k2", {15'b0, rempty_o}, 16'h0);
    chk("single_data", rdata_o, 16'hA5C3);
    step(1'b0, '0, 1'b1, 1'b0);                     // k+3 pop
    chk("single_empty_k3", {15'b0, rempty_o}, 16'h1);
    step(1'b0, '0, 1'b0, 1'b0);                     // k+4
    chk("single_full_k4", {15'b0, wfull_o}, 16'h1);
    step(1'b0, '0, 1'b0, 1'b0);                     // k+5
    chk("single_free_k5", {15'b0, wfull_o}, 16'h0);

    // Writes blocked while full
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("blocked_data", rdata_o, 16'h1111);
    chk("blocked_full", {15'b0, wfull_o}, 16'h1);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("blocked_next", rdata_o, 16'h2222);
    chk("blocked_next_avail", {15'b0, rempty_o}, 16'h0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(S + 1);

    // Streaming 0..99 with both sides always requesting
    nxt = 0; rx_exp = 0; last_w = -1;
    for (int i = 0; i < 100 * 6 + 20 && rx_exp < 100; i++) begin
      step(nxt < 100, 16'(nxt), 1'b1, 1'b0);
      if (dut_wacc) begin
        if (last_w >= 0) chk("stream_spacing", 16'(cyc - last_w), 16'd6);
        last_w = cyc;
        nxt++;
      end
      if (dut_pop) begin
        chk("stream_order", pop_data, 16'(rx_exp));
        rx_exp++;
      end
    end
    chk("stream_count", 16'(rx_exp), 16'd100);
    idle(S + 1);

    // Reset while a word is in flight
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("midrst_rempty", {15'b0, rempty_o}, 16'h1);
    chk("midrst_wfull",  {15'b0, wfull_o},  16'h0);
    seen_beef = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (dut_pop && pop_data == 16'hBEEF) seen_beef = 1'b1;
    end
    chk("midrst_never_popped", {15'b0, seen_beef}, 16'h0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(1), 16'($urandom), $urandom_range(1),
           ($urandom_range(49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
